// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and default widths for the memory-stage controller.
package mem_stage_pkg;
  localparam int OPERAND_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} state_e;
endpackage

// File: rtl/mem_stage_ctrl_reg_16b.sv
// reg_16b: load-enabled register with asynchronous active-low clear.
module reg_16b #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         writeEn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_o <= '0;
    else if (writeEn) q_o <= d_i;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: issues loads/stores to a request/busy/done memory and stalls the pipeline
// until the access completes, with a same-cycle bypass when the memory answers immediately.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPERAND_WIDTH-1:0] ex_mem_AluRes,
  input  logic [OPERAND_WIDTH-1:0] ex_mem_writeData,
  input  logic                     ex_mem_MemRead,
  input  logic                     ex_mem_MemWrite,
  input  logic                     ex_mem_Halt,
  input  logic                     mem_busy,
  input  logic                     mem_done,
  input  logic [OPERAND_WIDTH-1:0] mem_rdata,
  output logic [OPERAND_WIDTH-1:0] mem_addr,
  output logic [OPERAND_WIDTH-1:0] mem_wdata,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [OPERAND_WIDTH-1:0] memDataOut,
  output logic                     mem_stall,
  output logic                     mem_err,
  output logic                     mem_err_sticky,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic sticky_q;
  logic [OPERAND_WIDTH-1:0] cap;
  logic any, req, idle, issue, hit;
  assign any = (ex_mem_MemRead | ex_mem_MemWrite) & ~ex_mem_Halt;
  assign req = any & ~ex_mem_AluRes[0];
  assign idle = state_q == IDLE;
  assign issue = idle & req & ~mem_busy;
  assign hit = issue & mem_done;
  reg_16b #(.W(OPERAND_WIDTH)) u_cap (
    .clk(clk), .rst(rst), .writeEn(state_q == WAIT && mem_done),
    .d_i(mem_rdata), .q_o(cap)
  );
  // Outputs are forced low while reset is held, even though inputs may be live.
  assign mem_addr = rst ? ex_mem_AluRes : '0;
  assign mem_wdata = rst ? ex_mem_writeData : '0;
  assign mem_wr = rst & issue & ex_mem_MemWrite;
  assign mem_rd = rst & issue & ex_mem_MemRead & ~ex_mem_MemWrite;
  assign mem_err = rst & any & ex_mem_AluRes[0];
  assign mem_stall = rst & ((idle & req & (mem_busy | ~mem_done)) | state_q == WAIT);
  assign memDataOut = !rst ? '0 : hit ? mem_rdata : state_q == RESP ? cap : '0;
  assign mem_err_sticky = sticky_q;
  assign stall_cnt = cnt_q;
  always_comb
    state_d = state_q == RESP ? IDLE :
              state_q == WAIT ? (mem_done ? RESP : WAIT) :
              (issue & ~mem_done) ? WAIT : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_stall && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      if (mem_err) sticky_q <= 1'b1;
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed test-plan sequences plus random traffic, checked against a
// transaction-level model of the memory stage.
module tb_mem_stage_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] addr = '0, wdata = '0, rdata = '0;
  logic rd = 0, wr = 0, halt = 0, busy = 0, done = 0;
  logic [15:0] o_addr, o_wdata, o_out, o_cnt;
  logic o_rd, o_wr, o_stall, o_err, o_sticky;
  logic [15:0] q_addr, q_wdata, q_out;
  logic q_rd, q_wr, q_stall, q_err, q_sticky;
  logic [3:0] q_cnt;
  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .ex_mem_AluRes(addr), .ex_mem_writeData(wdata),
    .ex_mem_MemRead(rd), .ex_mem_MemWrite(wr), .ex_mem_Halt(halt),
    .mem_busy(busy), .mem_done(done), .mem_rdata(rdata),
    .mem_addr(o_addr), .mem_wdata(o_wdata), .mem_rd(o_rd), .mem_wr(o_wr),
    .memDataOut(o_out), .mem_stall(o_stall), .mem_err(o_err),
    .mem_err_sticky(o_sticky), .stall_cnt(o_cnt)
  );
  mem_stage_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ex_mem_AluRes(addr), .ex_mem_writeData(wdata),
    .ex_mem_MemRead(rd), .ex_mem_MemWrite(wr), .ex_mem_Halt(halt),
    .mem_busy(busy), .mem_done(done), .mem_rdata(rdata),
    .mem_addr(q_addr), .mem_wdata(q_wdata), .mem_rd(q_rd), .mem_wr(q_wr),
    .memDataOut(q_out), .mem_stall(q_stall), .mem_err(q_err),
    .mem_err_sticky(q_sticky), .stall_cnt(q_cnt)
  );
  int n_chk = 0, n_pass = 0;
  bit m_wait, m_resp, m_sticky, last_stall;
  logic [15:0] m_cap;
  int m_cnt, m_cnt4;
  logic e_rd, e_wr, e_stall, e_err;
  logic [15:0] e_out;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic predict();
    bit any, req;
    any = (rd | wr) & !halt;
    req = any & !addr[0];
    {e_rd, e_wr, e_stall, e_err} = '0;
    e_out = '0;
    if (!rst) return;
    e_err = any & addr[0];
    if (m_wait) e_stall = 1;
    else if (m_resp) e_out = m_cap;
    else if (req) begin
      if (busy) e_stall = 1;
      else begin
        e_wr = wr;
        e_rd = rd & !wr;
        if (done) e_out = rdata; else e_stall = 1;
      end
    end
  endtask
  task automatic advance();
    if (!rst) begin
      {m_wait, m_resp, m_sticky} = '0;
      m_cap = '0; m_cnt = 0; m_cnt4 = 0;
      return;
    end
    if (e_stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (e_err) m_sticky = 1;
    if (m_wait) begin
      if (done) begin m_wait = 0; m_resp = 1; m_cap = rdata; end
    end else if (m_resp) m_resp = 0;
    else if ((e_rd | e_wr) && !done) m_wait = 1;
  endtask
  task automatic check_all();
    predict();
    chk("mem_rd", o_rd, e_rd);
    chk("mem_wr", o_wr, e_wr);
    chk("mem_stall", o_stall, e_stall);
    chk("memDataOut", o_out, e_out);
    chk("mem_err", o_err, e_err);
    chk("mem_err_sticky", o_sticky, m_sticky);
    chk("stall_cnt", o_cnt, m_cnt);
    chk("stall_cnt4", q_cnt, m_cnt4);
    chk("mem_addr", o_addr, rst ? addr : 16'h0);
    chk("mem_wdata", o_wdata, rst ? wdata : 16'h0);
    chk("stall4", q_stall, e_stall);
  endtask
  task automatic step();
    @(negedge clk);
    check_all();
    advance();
    last_stall = e_stall;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    {rd, wr, halt, busy, done} = '0;
  endtask
  initial begin
    advance();
    rd = 1; addr = 16'h0010; done = 1; rdata = 16'h5555;
    step(); step();
    rst = 1; idle_in();
    step();
    rd = 1; addr = 16'h0010; done = 1; rdata = 16'hBEEF;
    step();
    idle_in(); step();
    rd = 1; addr = 16'h0020; rdata = 16'h0000;
    step(); step();
    done = 1; rdata = 16'h1234; step();
    done = 0; step();
    idle_in(); step();
    wr = 1; wdata = 16'h00FF; addr = 16'h0040; busy = 1;
    step(); step();
    busy = 0; done = 1; step();
    idle_in(); step();
    rd = 1; addr = 16'h0031; step();
    rd = 0; halt = 1; wr = 1; step();
    idle_in(); step();
    rd = 1; wr = 1; addr = 16'h0042; done = 1; rdata = 16'hA5A5; step();
    idle_in(); rd = 1; addr = 16'h0050; step(); step();
    rst = 0; #1;
    advance(); check_all();
    step();
    rst = 1; rd = 0; done = 1; rdata = 16'hDEAD;
    step(); step();
    idle_in(); rd = 1; addr = 16'h0060;
    for (int i = 0; i < 20; i++) step();
    done = 1; rdata = 16'h7777; step();
    idle_in(); step(); step();
    last_stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        rd = ($urandom % 2) == 0;
        wr = ($urandom % 3) == 0;
        halt = ($urandom % 8) == 0;
        addr = 16'($urandom) & 16'hFFFE;
        if (($urandom % 8) == 0) addr[0] = 1'b1;
        wdata = 16'($urandom);
      end
      busy = ($urandom % 4) == 0;
      done = ($urandom % 3) == 0;
      rdata = 16'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
